// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: ID/EX operands and controls coming in, EX/MEM bundle going out.
// slave = execute stage view, master = driver/observer view.
interface ex_mem_stage_if #(
    parameter int XLEN = 64
);
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rd1_in;
    logic [XLEN-1:0] rd2_in;
    logic [XLEN-1:0] imm_in;
    logic [4:0]      rs1_in;
    logic [4:0]      rs2_in;
    logic [4:0]      write_reg_in;
    logic [3:0]      alu_control_signal;
    logic            alusrc_in;
    logic            branch_in;
    logic            memwrite_in;
    logic            memread_in;
    logic            memtoreg_in;
    logic            regwrite_in;
    logic [4:0]      mem_wb_rd;
    logic            mem_wb_regwrite;
    logic [XLEN-1:0] wb_data;
    logic [1:0]      forward_a;
    logic [1:0]      forward_b;
    logic [XLEN-1:0] pc_out;
    logic            zero_out;
    logic [XLEN-1:0] alu_result_out;
    logic [XLEN-1:0] store_data_out;
    logic [4:0]      write_reg_out;
    logic            branch_out;
    logic            memwrite_out;
    logic            memread_out;
    logic            memtoreg_out;
    logic            regwrite_out;

    modport slave (
        input  pc_in, rd1_in, rd2_in, imm_in,
        input  rs1_in, rs2_in, write_reg_in,
        input  alu_control_signal, alusrc_in,
        input  branch_in, memwrite_in, memread_in,
        input  memtoreg_in, regwrite_in,
        input  mem_wb_rd, mem_wb_regwrite, wb_data,
        output forward_a, forward_b,
        output pc_out, zero_out, alu_result_out,
        output store_data_out, write_reg_out,
        output branch_out, memwrite_out, memread_out,
        output memtoreg_out, regwrite_out
    );

    modport master (
        output pc_in, rd1_in, rd2_in, imm_in,
        output rs1_in, rs2_in, write_reg_in,
        output alu_control_signal, alusrc_in,
        output branch_in, memwrite_in, memread_in,
        output memtoreg_in, regwrite_in,
        output mem_wb_rd, mem_wb_regwrite, wb_data,
        input  forward_a, forward_b,
        input  pc_out, zero_out, alu_result_out,
        input  store_data_out, write_reg_out,
        input  branch_out, memwrite_out, memread_out,
        input  memtoreg_out, regwrite_out
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: RV64 execute stage -- forwarding, ALU, branch target, EX/MEM register.
// Ports: clk, rst (async active-low), bus (ex_mem_stage_if.slave). Option: ALU_EXT_OPS_EN.
module ex_mem_stage #(
    parameter int XLEN = 64
) (
    input logic          clk,
    input logic          rst,
    ex_mem_stage_if.slave bus
);
    logic            exm_hit_a;
    logic            exm_hit_b;
    logic            wb_hit_a;
    logic            wb_hit_b;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] target;

    // x0 is hardwired zero, so a write to it is never a producer.
    assign exm_hit_a = bus.regwrite_out && (bus.write_reg_out != 5'd0)
                       && (bus.write_reg_out == bus.rs1_in);
    assign exm_hit_b = bus.regwrite_out && (bus.write_reg_out != 5'd0)
                       && (bus.write_reg_out == bus.rs2_in);
    assign wb_hit_a  = bus.mem_wb_regwrite && (bus.mem_wb_rd != 5'd0)
                       && (bus.mem_wb_rd == bus.rs1_in);
    assign wb_hit_b  = bus.mem_wb_regwrite && (bus.mem_wb_rd != 5'd0)
                       && (bus.mem_wb_rd == bus.rs2_in);

    // Newer EX/MEM producer wins; terms are made exclusive for the decoder.
    always_comb begin
        fwd_a = 2'b00;
        unique case (1'b1)
            exm_hit_a:             fwd_a = 2'b10;
            wb_hit_a && !exm_hit_a: fwd_a = 2'b01;
            default:               fwd_a = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b = 2'b00;
        unique case (1'b1)
            exm_hit_b:             fwd_b = 2'b10;
            wb_hit_b && !exm_hit_b: fwd_b = 2'b01;
            default:               fwd_b = 2'b00;
        endcase
    end

    assign bus.forward_a = fwd_a;
    assign bus.forward_b = fwd_b;

    always_comb begin
        op_a = bus.rd1_in;
        case (fwd_a)
            2'b10:   op_a = bus.alu_result_out;
            2'b01:   op_a = bus.wb_data;
            default: op_a = bus.rd1_in;
        endcase
    end

    // rs2 is forwarded before the immediate mux so stores see fresh data.
    always_comb begin
        rs2_val = bus.rd2_in;
        case (fwd_b)
            2'b10:   rs2_val = bus.alu_result_out;
            2'b01:   rs2_val = bus.wb_data;
            default: rs2_val = bus.rd2_in;
        endcase
    end

    assign op_b = bus.alusrc_in ? bus.imm_in : rs2_val;

    always_comb begin
        result = '0;
        case (bus.alu_control_signal)
            4'b0000: result = op_a & op_b;
            4'b0001: result = op_a | op_b;
            4'b0010: result = op_a + op_b;
            4'b0110: result = op_a - op_b;
`ifdef ALU_EXT_OPS_EN
            4'b0011: result = op_a ^ op_b;
            4'b0100: result = op_a << op_b[5:0];
            4'b0101: result = op_a >> op_b[5:0];
            4'b0111: result = {{(XLEN-1){1'b0}},
                               $signed(op_a) < $signed(op_b)};
            4'b1000: result = $signed(op_a) >>> op_b[5:0];
`endif
            default: result = '0;
        endcase
    end

    assign target = bus.pc_in + (bus.imm_in << 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.pc_out         <= '0;
            bus.zero_out       <= 1'b0;
            bus.alu_result_out <= '0;
            bus.store_data_out <= '0;
            bus.write_reg_out  <= 5'd0;
            bus.branch_out     <= 1'b0;
            bus.memwrite_out   <= 1'b0;
            bus.memread_out    <= 1'b0;
            bus.memtoreg_out   <= 1'b0;
            bus.regwrite_out   <= 1'b0;
        end else begin
            bus.pc_out         <= target;
            bus.zero_out       <= (result == '0);
            bus.alu_result_out <= result;
            bus.store_data_out <= rs2_val;
            bus.write_reg_out  <= bus.write_reg_in;
            bus.branch_out     <= bus.branch_in;
            bus.memwrite_out   <= bus.memwrite_in;
            bus.memread_out    <= bus.memread_in;
            bus.memtoreg_out   <= bus.memtoreg_in;
            bus.regwrite_out   <= bus.regwrite_in;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed vectors for ex_mem_stage with a spec-level model
// compared every falling edge, plus hand-computed literal expectations.
module tb_ex_mem_stage;
    logic clk;
    logic rst;
    logic chk_en;
    int   passed;
    int   total;

    ex_mem_stage_if #(.XLEN(64)) bus ();

    ex_mem_stage #(.XLEN(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the EX/MEM contents: what the memory stage should be holding.
    logic [63:0] m_pc, m_alu, m_st;
    logic [4:0]  m_wr;
    logic        m_zero, m_br, m_mw, m_mr, m_m2r, m_rw;

    function automatic logic [63:0] alu_fn(input logic [3:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
        logic [63:0] r;
        r = 64'd0;
        if (op == 4'd0) r = a & b;
        else if (op == 4'd1) r = a | b;
        else if (op == 4'd2) r = a + b;
        else if (op == 4'd6) r = a - b;
`ifdef ALU_EXT_OPS_EN
        else if (op == 4'd3) r = a ^ b;
        else if (op == 4'd4) r = a << b[5:0];
        else if (op == 4'd5) r = a >> b[5:0];
        else if (op == 4'd7) r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
        else if (op == 4'd8) r = $signed(a) >>> b[5:0];
`endif
        return r;
    endfunction

    // Which pipeline slot holds the newest value of register rs.
    function automatic logic [1:0] exp_sel(input logic [4:0] rs);
        if (rs == 5'd0) return 2'b00;
        if (m_rw && m_wr == rs) return 2'b10;
        if (bus.mem_wb_regwrite && bus.mem_wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [63:0] newest(input logic [4:0] rs,
                                           input logic [63:0] rf);
        logic [1:0] s;
        s = exp_sel(rs);
        if (s == 2'b10) return m_alu;
        if (s == 2'b01) return bus.wb_data;
        return rf;
    endfunction

    always @(posedge clk or negedge rst) begin
        logic [63:0] a, s2, b, r;
        if (!rst) begin
            m_pc = 0; m_alu = 0; m_st = 0; m_wr = 0; m_zero = 0;
            m_br = 0; m_mw = 0; m_mr = 0; m_m2r = 0; m_rw = 0;
        end else begin
            a  = newest(bus.rs1_in, bus.rd1_in);
            s2 = newest(bus.rs2_in, bus.rd2_in);
            b  = bus.alusrc_in ? bus.imm_in : s2;
            r  = alu_fn(bus.alu_control_signal, a, b);
            m_pc   = bus.pc_in + bus.imm_in * 2;
            m_alu  = r;
            m_zero = (r == 0);
            m_st   = s2;
            m_wr   = bus.write_reg_in;
            m_br   = bus.branch_in;
            m_mw   = bus.memwrite_in;
            m_mr   = bus.memread_in;
            m_m2r  = bus.memtoreg_in;
            m_rw   = bus.regwrite_in;
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_forward_a", 64'(bus.forward_a), 64'(exp_sel(bus.rs1_in)));
            check("m_forward_b", 64'(bus.forward_b), 64'(exp_sel(bus.rs2_in)));
            check("m_pc_out", bus.pc_out, m_pc);
            check("m_alu_result", bus.alu_result_out, m_alu);
            check("m_zero", 64'(bus.zero_out), 64'(m_zero));
            check("m_store_data", bus.store_data_out, m_st);
            check("m_write_reg", 64'(bus.write_reg_out), 64'(m_wr));
            check("m_ctrl", {59'd0, bus.branch_out, bus.memwrite_out,
                             bus.memread_out, bus.memtoreg_out,
                             bus.regwrite_out},
                  {59'd0, m_br, m_mw, m_mr, m_m2r, m_rw});
        end
    end

    task automatic clear_in();
        bus.pc_in = 0; bus.rd1_in = 0; bus.rd2_in = 0; bus.imm_in = 0;
        bus.rs1_in = 0; bus.rs2_in = 0; bus.write_reg_in = 0;
        bus.alu_control_signal = 0; bus.alusrc_in = 0;
        bus.branch_in = 0; bus.memwrite_in = 0; bus.memread_in = 0;
        bus.memtoreg_in = 0; bus.regwrite_in = 0;
        bus.mem_wb_rd = 0; bus.mem_wb_regwrite = 0; bus.wb_data = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"}, bus.pc_out, 64'd0);
        check({tag, "_alu"}, bus.alu_result_out, 64'd0);
        check({tag, "_store"}, bus.store_data_out, 64'd0);
        check({tag, "_ctrl"}, {53'd0, bus.write_reg_out, bus.zero_out,
              bus.branch_out, bus.memwrite_out, bus.memread_out,
              bus.memtoreg_out, bus.regwrite_out}, 64'd0);
        check({tag, "_fwd"}, {60'd0, bus.forward_a, bus.forward_b}, 64'd0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        clear_in();
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;
        step();
        check_all_zero("reset_init");
        rst = 1'b1;

        // ADD, no hazard
        clear_in();
        bus.rd1_in = 5; bus.rd2_in = 7; bus.alu_control_signal = 4'b0010;
        bus.write_reg_in = 3;
        step();
        check("add_result", bus.alu_result_out, 64'd12);
        check("add_zero", 64'(bus.zero_out), 64'd0);
        check("add_wr", 64'(bus.write_reg_out), 64'd3);

        // SUB to zero with branch target
        clear_in();
        bus.rd1_in = 9; bus.rd2_in = 9; bus.alu_control_signal = 4'b0110;
        bus.branch_in = 1; bus.pc_in = 64'h40; bus.imm_in = 8;
        step();
        check("sub_zero", 64'(bus.zero_out), 64'd1);
        check("sub_target", bus.pc_out, 64'h50);
        check("sub_branch", 64'(bus.branch_out), 64'd1);

        // x5 = 2 + 3, then consume x5 from EX/MEM
        clear_in();
        bus.rd1_in = 2; bus.rd2_in = 3; bus.alu_control_signal = 4'b0010;
        bus.write_reg_in = 5; bus.regwrite_in = 1;
        step();
        check("prod_x5", bus.alu_result_out, 64'd5);
        clear_in();
        bus.rs1_in = 5; bus.alu_control_signal = 4'b0010;
        bus.alusrc_in = 1; bus.imm_in = 1;
        bus.write_reg_in = 4; bus.regwrite_in = 1;
        #1 check("exm_fwd_a", 64'(bus.forward_a), 64'd2);
        step();
        check("exm_fwd_result", bus.alu_result_out, 64'd6);

        // x4 in both EX/MEM and MEM/WB: EX/MEM must win
        clear_in();
        bus.rs2_in = 4; bus.rd2_in = 64'h1234; bus.rd1_in = 1;
        bus.mem_wb_rd = 4; bus.mem_wb_regwrite = 1; bus.wb_data = 64'h99;
        bus.alu_control_signal = 4'b0010;
        #1 check("prio_fwd_b", 64'(bus.forward_b), 64'd2);
        step();
        check("prio_result", bus.alu_result_out, 64'd7);
        check("prio_store", bus.store_data_out, 64'd6);

        // x0 from MEM/WB is never forwarded; next write x0 in EX/MEM
        clear_in();
        bus.mem_wb_regwrite = 1; bus.mem_wb_rd = 0; bus.wb_data = 64'hdead;
        bus.rd1_in = 64'h11; bus.rd2_in = 64'h22;
        bus.alu_control_signal = 4'b0001;
        bus.write_reg_in = 0; bus.regwrite_in = 1;
        #1 check("x0_wb_fwd_a", 64'(bus.forward_a), 64'd0);
        step();
        check("or_result", bus.alu_result_out, 64'h33);
        clear_in();
        bus.rd1_in = 64'hF0; bus.rd2_in = 64'hFF;
        #1 check("x0_exm_fwd_a", 64'(bus.forward_a), 64'd0);
        step();
        check("and_result", bus.alu_result_out, 64'hF0);

        // MEM/WB forward into store data
        clear_in();
        bus.mem_wb_rd = 6; bus.mem_wb_regwrite = 1; bus.wb_data = 64'hABCD;
        bus.rs2_in = 6; bus.alusrc_in = 1; bus.imm_in = 16;
        bus.alu_control_signal = 4'b0010; bus.memwrite_in = 1;
        #1 check("wb_fwd_b", 64'(bus.forward_b), 64'd1);
        step();
        check("wb_result", bus.alu_result_out, 64'd16);
        check("wb_store", bus.store_data_out, 64'hABCD);

        // Modulo wrap of ADD and branch target
        clear_in();
        bus.rd1_in = '1; bus.rd2_in = 1; bus.alu_control_signal = 4'b0010;
        bus.pc_in = '1; bus.imm_in = 1;
        bus.memread_in = 1; bus.memtoreg_in = 1;
        step();
        check("wrap_add", bus.alu_result_out, 64'd0);
        check("wrap_zero", 64'(bus.zero_out), 64'd1);
        check("wrap_target", bus.pc_out, 64'd1);

        clear_in();
        bus.rd1_in = 0; bus.rd2_in = 1; bus.alu_control_signal = 4'b0110;
        step();
        check("wrap_sub", bus.alu_result_out, 64'hFFFF_FFFF_FFFF_FFFF);

        clear_in();
        bus.rd1_in = 5; bus.rd2_in = 3; bus.alu_control_signal = 4'b1111;
        step();
        check("bad_op", bus.alu_result_out, 64'd0);
        clear_in();
        bus.rd1_in = 5; bus.rd2_in = 3; bus.alu_control_signal = 4'b0011;
        step();
        clear_in();
        bus.rd1_in = 64'h8000_0000_0000_0000; bus.rd2_in = 4;
        bus.alu_control_signal = 4'b1000;
        step();

        // Instruction that is its own source keeps forwarding
        clear_in();
        bus.rd1_in = 10; bus.alusrc_in = 1; bus.imm_in = 0;
        bus.alu_control_signal = 4'b0010;
        bus.write_reg_in = 7; bus.regwrite_in = 1;
        step();
        bus.rs1_in = 7; bus.rd1_in = 0; bus.imm_in = 1;
        #1 check("self_fwd_a", 64'(bus.forward_a), 64'd2);
        step();
        check("self_1", bus.alu_result_out, 64'd11);
        step();
        check("self_2", bus.alu_result_out, 64'd12);

        // Asynchronous reset mid-cycle with regwrite_in still high
        #2 rst = 1'b0;
        #1 check_all_zero("reset_async");
        step();
        check_all_zero("reset_held");
        rst = 1'b1;
        step();
        check("post_reset", bus.alu_result_out, 64'd1);
        check("post_reset_rw", 64'(bus.regwrite_out), 64'd1);

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
